// File: rtl/front_panel_ctrl_pkg.sv
// Shared definitions for the PDP-8 console key conditioner: FSM states,
// key indices in descending priority, and a counter width helper.
package front_panel_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_POR      = 2'd0,
        ST_CLEARING = 2'd1,
        ST_IDLE     = 2'd2,
        ST_HOLDOFF  = 2'd3
    } panel_state_t;

    localparam int unsigned NUM_KEYS  = 5;

    // Lower index wins when several presses land in the same cycle
    localparam int unsigned KEY_CLEAR = 0;
    localparam int unsigned KEY_HALT  = 1;
    localparam int unsigned KEY_RUN   = 2;
    localparam int unsigned KEY_STEPI = 3;
    localparam int unsigned KEY_STEPM = 4;

    // Bits needed for a down/up counter spanning 0..n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/front_panel_ctrl_debounce.sv
// One console key: 2-flop synchroniser, equal-sample debounce counter and
// a registered single-cycle pulse on the debounced 0->1 edge.
module front_panel_ctrl_debounce
    import front_panel_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // Bring the asynchronous key into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key};
        end
    end

    // Flip the level only after a full run of differing samples; any agreeing sample restarts the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                level <= sync_q[1];
                press <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/front_panel_ctrl.sv
// PDP-8 front panel controller: turns debounced console keys into single
// sw_* strobes for the CPU sequencer, with run-state interlock, fixed key
// priority, post-strobe holdoff and a power-on CLEAR.
// Optional STEPI auto-repeat is built when PANEL_AUTOREPEAT_EN is defined.
module front_panel_ctrl
    import front_panel_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CLEAR_CYCLES    = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 2
`ifdef PANEL_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 32
`endif
) (
    input  logic SYSCLK,
    input  logic RESETn,
    input  logic key_CLEAR,
    input  logic key_RUN,
    input  logic key_HALT,
    input  logic key_STEPM,
    input  logic key_STEPI,
    input  logic running,
    output logic sw_CLEAR,
    output logic sw_RUN,
    output logic sw_HALT,
    output logic sw_STEPM,
    output logic sw_STEPI,
    output logic panelBusy
);

    localparam int unsigned SW = cnt_width((CLEAR_CYCLES > HOLDOFF_CYCLES) ? CLEAR_CYCLES : HOLDOFF_CYCLES);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_lvl;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] win_c;
    logic                stepi_req_c;
    logic                unused_lvl;
    panel_state_t        state;
    logic [SW-1:0]       cnt;

    assign key_raw[KEY_CLEAR] = key_CLEAR;
    assign key_raw[KEY_HALT]  = key_HALT;
    assign key_raw[KEY_RUN]   = key_RUN;
    assign key_raw[KEY_STEPI] = key_STEPI;
    assign key_raw[KEY_STEPM] = key_STEPM;

    // Levels are only consumed by auto-repeat
    assign unused_lvl = ^key_lvl;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        front_panel_ctrl_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (SYSCLK),
            .rst_n(RESETn),
            .key  (key_raw[i]),
            .level(key_lvl[i]),
            .press(key_press[i])
        );
    end

`ifdef PANEL_AUTOREPEAT_EN
    localparam int unsigned RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_active;
    logic          rpt_due_c;
    logic          stepi_fire_c;

    assign rpt_due_c    = rpt_active && (rpt_cnt == '0) && key_lvl[KEY_STEPI] && !running;
    assign stepi_req_c  = key_press[KEY_STEPI] | rpt_due_c;
    assign stepi_fire_c = (state == ST_IDLE) && win_c[KEY_STEPI];

    // Time the next repeat from each issued STEPI strobe; a pending repeat waits at zero for IDLE
    always_ff @(posedge SYSCLK or negedge RESETn) begin
        if (!RESETn) begin
            rpt_cnt    <= '0;
            rpt_active <= 1'b0;
        end else if (!key_lvl[KEY_STEPI] || running) begin
            rpt_active <= 1'b0;
        end else if (stepi_fire_c) begin
            rpt_active <= 1'b1;
            rpt_cnt    <= rpt_due_c ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
        end else if (rpt_cnt != '0) begin
            rpt_cnt <= rpt_cnt - RW'(1);
        end
    end
`else
    assign stepi_req_c = key_press[KEY_STEPI];
`endif

    // Pick the highest-priority press first, then apply the run-state interlock to that winner only
    always_comb begin
        win_c = '0;
        if (key_press[KEY_CLEAR]) begin
            win_c[KEY_CLEAR] = 1'b1;
        end else if (key_press[KEY_HALT]) begin
            win_c[KEY_HALT] = running;
        end else if (key_press[KEY_RUN]) begin
            win_c[KEY_RUN] = !running;
        end else if (stepi_req_c) begin
            win_c[KEY_STEPI] = !running;
        end else if (key_press[KEY_STEPM]) begin
            win_c[KEY_STEPM] = !running;
        end
    end

    // Panel sequencer with registered strobes and busy flag
    always_ff @(posedge SYSCLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= ST_POR;
            cnt       <= '0;
            sw_CLEAR  <= 1'b0;
            sw_RUN    <= 1'b0;
            sw_HALT   <= 1'b0;
            sw_STEPM  <= 1'b0;
            sw_STEPI  <= 1'b0;
            panelBusy <= 1'b1;
        end else begin
            sw_CLEAR  <= 1'b0;
            sw_RUN    <= 1'b0;
            sw_HALT   <= 1'b0;
            sw_STEPM  <= 1'b0;
            sw_STEPI  <= 1'b0;
            panelBusy <= 1'b1;
            unique case (state)
                ST_POR: begin
                    state    <= ST_CLEARING;
                    cnt      <= SW'(CLEAR_CYCLES - 1);
                    sw_CLEAR <= 1'b1;
                end
                ST_CLEARING: begin
                    if (cnt == '0) begin
                        state <= ST_HOLDOFF;
                        cnt   <= SW'(HOLDOFF_CYCLES - 1);
                    end else begin
                        cnt      <= cnt - SW'(1);
                        sw_CLEAR <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    panelBusy <= 1'b0;
                    if (win_c[KEY_CLEAR]) begin
                        state     <= ST_CLEARING;
                        cnt       <= SW'(CLEAR_CYCLES - 1);
                        sw_CLEAR  <= 1'b1;
                        panelBusy <= 1'b1;
                    end else if (|win_c) begin
                        state     <= ST_HOLDOFF;
                        cnt       <= SW'(HOLDOFF_CYCLES - 1);
                        sw_HALT   <= win_c[KEY_HALT];
                        sw_RUN    <= win_c[KEY_RUN];
                        sw_STEPI  <= win_c[KEY_STEPI];
                        sw_STEPM  <= win_c[KEY_STEPM];
                        panelBusy <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == '0) begin
                        state     <= ST_IDLE;
                        panelBusy <= 1'b0;
                    end else begin
                        cnt <= cnt - SW'(1);
                    end
                end
                default: state <= ST_POR;
            endcase
        end
    end

    // The CPU must never see two panel strobes at once
    assert property (@(posedge SYSCLK) disable iff (!RESETn)
        $onehot0({sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI}));

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Scoreboard bench for front_panel_ctrl: stimulus queues expected strobes
// (code + cycle), a forked monitor compares every non-idle strobe cycle.
module tb_front_panel_ctrl;

    logic SYSCLK = 1'b0;
    logic RESETn = 1'b0;
    logic key_CLEAR = 1'b0;
    logic key_RUN = 1'b0;
    logic key_HALT = 1'b0;
    logic key_STEPM = 1'b0;
    logic key_STEPI = 1'b0;
    logic running = 1'b0;
    logic sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI, panelBusy;

    localparam logic [4:0] E_CLEAR = 5'b10000;
    localparam logic [4:0] E_HALT  = 5'b01000;
    localparam logic [4:0] E_RUN   = 5'b00100;
    localparam logic [4:0] E_STEPI = 5'b00010;
    localparam logic [4:0] E_STEPM = 5'b00001;
    localparam int unsigned LAT    = 19;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    front_panel_ctrl dut (
        .SYSCLK   (SYSCLK),
        .RESETn   (RESETn),
        .key_CLEAR(key_CLEAR),
        .key_RUN  (key_RUN),
        .key_HALT (key_HALT),
        .key_STEPM(key_STEPM),
        .key_STEPI(key_STEPI),
        .running  (running),
        .sw_CLEAR (sw_CLEAR),
        .sw_RUN   (sw_RUN),
        .sw_HALT  (sw_HALT),
        .sw_STEPM (sw_STEPM),
        .sw_STEPI (sw_STEPI),
        .panelBusy(panelBusy)
    );

    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic expect_sw(input logic [4:0] code, input int unsigned at);
        exp_q.push_back('{code: code, cyc: at});
    endtask

    task automatic expect_clear(input int unsigned first);
        for (int k = 0; k < 4; k++) expect_sw(E_CLEAR, first + k);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b want %b at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Pops the scoreboard on every strobe cycle; reports overdue expectations as missing
    task automatic monitor();
        logic [4:0] v;
        exp_t       e;
        forever begin
            @(negedge SYSCLK);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL strobe missing: got none want %b at cycle %0d", e.code, e.cyc);
            end
            v = {sw_CLEAR, sw_HALT, sw_RUN, sw_STEPI, sw_STEPM};
            if (v != 5'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe unexpected: got %b at cycle %0d want none", v, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.code !== v || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL strobe: got %b at cycle %0d want %b at cycle %0d",
                                 v, cyc, e.code, e.cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned p;
        int unsigned r;
        exp_t        e;
        fork
            monitor();
        join_none

        // Reset state
        tick(3);
        check_bit("reset sw_CLEAR", sw_CLEAR, 1'b0);
        check_bit("reset sw_RUN", sw_RUN | sw_HALT | sw_STEPM | sw_STEPI, 1'b0);
        check_bit("reset panelBusy", panelBusy, 1'b1);

        // Power-on CLEAR
        r = cyc;
        expect_clear(r + 1);
        RESETn = 1'b1;
        tick(6);
        check_bit("por busy cycle 6", panelBusy, 1'b1);
        tick(1);
        check_bit("por busy cycle 7", panelBusy, 1'b0);

        // Clean RUN press, no strobe on release
        tick(5);
        p = cyc; key_RUN = 1'b1; expect_sw(E_RUN, p + LAT);
        tick(30); key_RUN = 1'b0; tick(30);

        // Bouncing STEPI settles to a single strobe
        for (int i = 0; i < 8; i++) begin
            key_STEPI = (i % 2 == 0);
            tick(5);
        end
        p = cyc; key_STEPI = 1'b1; expect_sw(E_STEPI, p + LAT);
        tick(60); key_STEPI = 1'b0; tick(30);

        // STEPI beats STEPM; then STEPM alone
        p = cyc; key_STEPI = 1'b1; key_STEPM = 1'b1; expect_sw(E_STEPI, p + LAT);
        tick(40); key_STEPI = 1'b0; key_STEPM = 1'b0; tick(30);
        p = cyc; key_STEPM = 1'b1; expect_sw(E_STEPM, p + LAT);
        tick(30); key_STEPM = 1'b0; tick(30);

        // HALT+RUN together: HALT when running, nothing when stopped
        running = 1'b1;
        p = cyc; key_HALT = 1'b1; key_RUN = 1'b1; expect_sw(E_HALT, p + LAT);
        tick(30); key_HALT = 1'b0; key_RUN = 1'b0; tick(30);
        running = 1'b0;
        key_HALT = 1'b1; key_RUN = 1'b1;
        tick(30); key_HALT = 1'b0; key_RUN = 1'b0; tick(30);

        // RUN while running is rejected
        running = 1'b1;
        key_RUN = 1'b1; tick(30); key_RUN = 1'b0; tick(30);
        running = 1'b0;

        // CLEAR arriving during the holdoff after RUN is discarded
        p = cyc; key_RUN = 1'b1; expect_sw(E_RUN, p + LAT);
        tick(1); key_CLEAR = 1'b1;
        tick(40); key_RUN = 1'b0; key_CLEAR = 1'b0; tick(30);

        // Keyed CLEAR: 4 cycles wide, busy through holdoff
        p = cyc; key_CLEAR = 1'b1; expect_clear(p + LAT);
        tick(24);
        check_bit("keyed clear busy +24", panelBusy, 1'b1);
        tick(1);
        check_bit("keyed clear busy +25", panelBusy, 1'b0);
        tick(20); key_CLEAR = 1'b0; tick(30);

        // Reset in the middle of CLEARING, then a fresh CLEAR
        @(negedge SYSCLK); #2 RESETn = 1'b0;
        tick(3);
        r = cyc; expect_sw(E_CLEAR, r + 1); expect_sw(E_CLEAR, r + 2);
        RESETn = 1'b1;
        tick(2);
        #2 RESETn = 1'b0;
        #1;
        check_bit("mid-clear reset sw_CLEAR", sw_CLEAR, 1'b0);
        check_bit("mid-clear reset busy", panelBusy, 1'b1);
        tick(3);
        r = cyc; expect_clear(r + 1);
        RESETn = 1'b1;
        tick(7);
        check_bit("re-por busy cycle 7", panelBusy, 1'b0);

        // STEPI held 200 cycles
        tick(10);
        p = cyc; key_STEPI = 1'b1; expect_sw(E_STEPI, p + LAT);
`ifdef PANEL_AUTOREPEAT_EN
        expect_sw(E_STEPI, p + LAT + 64);
        for (int k = 1; k <= 4; k++) expect_sw(E_STEPI, p + LAT + 64 + 32 * k);
`endif
        tick(200); key_STEPI = 1'b0; tick(40);

        tick(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL strobe missing at end: got none want %b at cycle %0d", e.code, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
